// File: rtl/alu_wide_seq.sv
// alu_wide_seq: multi-cycle NBYTES-wide ADD/SUB/XOR/SHL built on the shared
// 8-bit combinational ALU. It issues one byte slice per cycle, LSB first,
// and carries between slices. The result is returned through a valid/ready
// response.
// Optional build macro ALU_WIDE_SEQ_ZERO_EN adds the registered rsp_zero flag.

// ALU opcode constants used by the shared 8-bit ALU.
package definitionsABC;
  localparam logic [3:0] kADDL = 4'h0;  // a + b + sc_in, carry out on SC_OUT
  localparam logic [3:0] kXOR  = 4'h6;  // a ^ b
  localparam logic [3:0] kSLO  = 4'hA;  // {b[6:0], sc_in}, SC_OUT not driven

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_SHL = 2'b11
  } op_t;
endpackage

module alu_wide_seq
  import definitionsABC::*;
#(
  parameter  int NBYTES = 2,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic         req_cin,
  output logic [3:0]   alu_op,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_sc_in,
  input  logic [7:0]   alu_out,
  input  logic         alu_sc_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
`ifdef ALU_WIDE_SEQ_ZERO_EN
  output logic         rsp_zero,
`endif
  output logic         rsp_cout
);

  localparam int IDXW = $clog2(NBYTES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t          state;
  op_t             op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;        // holds ~B for SUB so the adder path is shared
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    result_q;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic            carry_nxt;
  logic [W-1:0]    result_nxt;

  assign req_ready  = (state == S_IDLE);
  assign rsp_result = result_q;

  // Select the current slice and drive the ALU; the ALU sits idle outside BUSY.
  always_comb begin
    // NOTE: assign every output a default first so that no path leaves one unassigned (no latch).
    alu_op    = kXOR;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_sc_in = 1'b0;
    a_byte    = a_q[{idx_q, 3'b000} +: 8];
    b_byte    = b_q[{idx_q, 3'b000} +: 8];
    if (state == S_BUSY) begin
      unique case (op_q)
        OP_ADD, OP_SUB: begin
          alu_op    = kADDL;
          alu_a     = a_byte;
          alu_b     = b_byte;
          alu_sc_in = carry_q;
        end
        OP_XOR: begin
          alu_op = kXOR;
          alu_a  = a_byte;
          alu_b  = b_byte;
        end
        OP_SHL: begin
          alu_op    = kSLO;
          alu_b     = a_byte;
          alu_sc_in = carry_q;
        end
        default: ;
      endcase
    end
  end

  // Carry into the next slice, and the result with the current slice merged in.
  always_comb begin
    carry_nxt  = 1'b0;
    result_nxt = result_q;
    result_nxt[{idx_q, 3'b000} +: 8] = alu_out;
    unique case (op_q)
      OP_ADD, OP_SUB: carry_nxt = alu_sc_out;
      OP_SHL:         carry_nxt = a_byte[7];  // kSLO leaves SC_OUT undriven
      default:        carry_nxt = 1'b0;
    endcase
  end

  // Sequencer FSM: accept, step slices LSB first, then hold the response.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the reset clears every register, including the operand and result registers, so nothing from an aborted operation survives.
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_XOR;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_cout  <= 1'b0;
`ifdef ALU_WIDE_SEQ_ZERO_EN
      rsp_zero  <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so that every register samples values from before the edge.
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q  <= op_t'(req_op);
            a_q   <= req_a;
            b_q   <= (op_t'(req_op) == OP_SUB) ? ~req_b : req_b;
            idx_q <= '0;
            state <= S_BUSY;
            unique case (op_t'(req_op))
              OP_ADD, OP_SHL: carry_q <= req_cin;
              OP_SUB:         carry_q <= 1'b1;  // two's complement: A + ~B + 1
              default:        carry_q <= 1'b0;
            endcase
          end
        end
        S_BUSY: begin
          result_q <= result_nxt;
          carry_q  <= carry_nxt;
          idx_q    <= idx_q + IDXW'(1);
          if (idx_q == LAST_IDX) begin
            state     <= S_DONE;
            rsp_valid <= 1'b1;
            rsp_cout  <= carry_nxt;
`ifdef ALU_WIDE_SEQ_ZERO_EN
            rsp_zero  <= (result_nxt == '0);
`endif
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq (NBYTES=2). It includes a behavioural
// model of the 8-bit ALU and a whole-word arithmetic reference model.
module tb_alu_wide_seq;
  import definitionsABC::*;

  localparam int NB = 2;
  localparam int W  = 8 * NB;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, XOR = 2'b10, SHL = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a, req_b;
  logic         req_cin;
  logic [3:0]   alu_op;
  logic [7:0]   alu_a, alu_b, alu_out;
  logic         alu_sc_in, alu_sc_out;
  logic         rsp_valid, rsp_ready, rsp_cout;
  logic [W-1:0] rsp_result;
`ifdef ALU_WIDE_SEQ_ZERO_EN
  logic         rsp_zero;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_wide_seq #(.NBYTES(NB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sc_in  (alu_sc_in),
    .alu_out    (alu_out),
    .alu_sc_out (alu_sc_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
`ifdef ALU_WIDE_SEQ_ZERO_EN
    .rsp_zero   (rsp_zero),
`endif
    .rsp_cout   (rsp_cout)
  );

  // Behavioural 8-bit ALU. For kSLO, SC_OUT is driven with a misleading value
  // so that a sequencer which wrongly uses it will produce a wrong carry.
  always_comb begin
    alu_out    = 8'h00;
    alu_sc_out = 1'b0;
    case (alu_op)
      kADDL:   {alu_sc_out, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc_in};
      kXOR:    alu_out = alu_a ^ alu_b;
      kSLO: begin
        alu_out    = {alu_b[6:0], alu_sc_in};
        alu_sc_out = ~alu_b[7];
      end
      default: alu_out = 8'h00;
    endcase
  end

  // Whole-word reference result.
  task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, b, input logic cin,
                           output logic [W-1:0] res, output logic cout);
    logic [W:0] s;
    case (op)
      ADD: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; res = s[W-1:0]; cout = s[W]; end
      SUB: begin res = a - b; cout = (a >= b); end
      XOR: begin res = a ^ b; cout = 1'b0; end
      default: begin res = {a[W-2:0], cin}; cout = a[W-1]; end
    endcase
  endtask

  // Expected ALU drive for slice k: {op, a, b, sc_in}. The carry into slice k
  // is bit 8k of the sum of the lower k bytes plus the initial carry.
  function automatic logic [20:0] exp_slice(input logic [1:0] op, input logic [W-1:0] a, b,
                                            input logic cin, input int k);
    logic [W:0] one, mask, sum;
    one  = 1;
    mask = (one << (8 * k)) - one;
    case (op)
      ADD: begin
        sum = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, cin};
        return {kADDL, a[8*k +: 8], b[8*k +: 8], sum[8*k]};
      end
      SUB: begin
        sum = ({1'b0, a} & mask) + ({1'b0, ~b} & mask) + one;
        return {kADDL, a[8*k +: 8], ~b[8*k +: 8], sum[8*k]};
      end
      XOR:     return {kXOR, a[8*k +: 8], b[8*k +: 8], 1'b0};
      default: return {kSLO, 8'h00, a[8*k +: 8], (k == 0) ? cin : a[8*k-1]};
    endcase
  endfunction

  // Runs one operation, optionally holding rsp_ready low for `hold` cycles
  // while poking a new request that must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input logic cin,
                        input int hold, input bit poke, input string name);
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic [20:0]  es;
    int           lat;
    ref_model(op, a, b, cin, exp_res, exp_cout);
    lat = 0;
    while (!req_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s req_ready_wait: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_a = W'($urandom); req_b = W'($urandom); req_cin = 1'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (lat < NB) begin
        es = exp_slice(op, a, b, cin, lat);
        tests++;
        if ({alu_op, alu_a, alu_b, alu_sc_in} !== es) begin
          fails++;
          $display("FAIL %s slice%0d alu{op,a,b,sc}: got %h,%h,%h,%b want %h,%h,%h,%b", name, lat,
                   alu_op, alu_a, alu_b, alu_sc_in, es[20:17], es[16:9], es[8:1], es[0]);
        end
      end
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat != NB || rsp_valid !== 1'b1) begin
      fails++; $display("FAIL %s latency: got %0d valid=%b want %0d", name, lat, rsp_valid, NB);
    end
    tests++;
    if (rsp_result !== exp_res || rsp_cout !== exp_cout) begin
      fails++; $display("FAIL %s result: got %h/%b want %h/%b", name, rsp_result, rsp_cout, exp_res, exp_cout);
    end
`ifdef ALU_WIDE_SEQ_ZERO_EN
    tests++;
    if (rsp_zero !== (exp_res == '0)) begin
      fails++; $display("FAIL %s zero: got %b want %b", name, rsp_zero, (exp_res == '0));
    end
`endif
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        req_valid = 1'b1; req_op = ADD; req_a = W'($urandom); req_b = W'($urandom); req_cin = 1'b1;
      end
      @(posedge clk); #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_res || rsp_cout !== exp_cout || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s hold%0d: got v=%b r=%h c=%b rdy=%b want v=1 r=%h c=%b rdy=0", name, h,
                 rsp_valid, rsp_result, rsp_cout, req_ready, exp_res, exp_cout);
      end
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_result !== exp_res) begin
      fails++;
      $display("FAIL %s release: got v=%b rdy=%b r=%h want v=0 rdy=1 r=%h", name, rsp_valid, req_ready,
               rsp_result, exp_res);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = ADD; req_a = '0; req_b = '0; req_cin = 1'b0;
    #12;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b v=%b r=%h c=%b want 1,0,0,0", req_ready, rsp_valid, rsp_result, rsp_cout);
    end
    tests++;
    if ({alu_op, alu_a, alu_b, alu_sc_in} !== {kXOR, 8'h00, 8'h00, 1'b0}) begin
      fails++; $display("FAIL reset_alu_idle: got %h,%h,%h,%b want %h,0,0,0", alu_op, alu_a, alu_b, alu_sc_in, kXOR);
    end
`ifdef ALU_WIDE_SEQ_ZERO_EN
    tests++;
    if (rsp_zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", rsp_zero); end
`endif
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    run_op(ADD, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "add_carry_chain");
    run_op(ADD, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "add_wrap");
    run_op(SUB, 16'h1234, 16'h0235, 1'b0, 0, 1'b0, "sub_no_borrow");
    run_op(SUB, 16'h0001, 16'h0002, 1'b1, 0, 1'b0, "sub_borrow");
    run_op(SHL, 16'h8081, 16'h5555, 1'b1, 0, 1'b0, "shl");
    run_op(XOR, 16'hA5A5, 16'hFFFF, 1'b1, 0, 1'b0, "xor");
  endtask

  task automatic test_backpressure;
    run_op(ADD, 16'h1357, 16'h2468, 1'b1, 5, 1'b1, "backpressure");
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL backpressure_no_accept: got rdy=%b v=%b want 1,0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
  endtask

  task automatic test_reset_mid_busy;
    req_valid = 1'b1; req_op = ADD; req_a = 16'hFFFF; req_b = 16'hFFFF; req_cin = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 ||
        {alu_op, alu_a, alu_b, alu_sc_in} !== {kXOR, 8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid_busy: got v=%b rdy=%b alu=%h,%h,%h,%b want 0,1,idle", rsp_valid, req_ready,
               alu_op, alu_a, alu_b, alu_sc_in);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_no_rsp: got v=%b want 0", rsp_valid); end
    run_op(ADD, 16'h0001, 16'h0001, 1'b0, 0, 1'b0, "add_after_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_reset_mid_busy;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
